// File: rtl/vga_pkg.sv
// -----------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA pixel packing path.
//   * ColorDepth encodings (CD_8BPP, CD_16BPP, CD_24BPP; 24bpp is any 2'b1x)
//   * pix_fmt_e       : decoded pixel format
//   * decode_depth()  : ColorDepth -> pix_fmt_e
//   * lane_mask()     : byte mask of the lanes already filled in a word
// -----------------------------------------------------------------------------
package vga_pkg;

  localparam logic [1:0] CD_8BPP  = 2'b00;
  localparam logic [1:0] CD_16BPP = 2'b01;
  localparam logic [1:0] CD_24BPP = 2'b10;  // 2'b11 is an alias

  typedef enum logic [1:0] {
    FMT_GREY,    // 1 byte per pixel
    FMT_RGB565,  // 2 bytes per pixel
    FMT_RGB888   // 3 bytes per pixel
  } pix_fmt_e;

  function automatic pix_fmt_e decode_depth(input logic [1:0] cd);
    pix_fmt_e fmt;
    case (cd)
      CD_8BPP:  fmt = FMT_GREY;
      CD_16BPP: fmt = FMT_RGB565;
      default:  fmt = FMT_RGB888;
    endcase
    return fmt;
  endfunction

  // Lanes fill from [31:24] downward, so bcnt filled bytes occupy the MSBs.
  function automatic logic [31:0] lane_mask(input logic [1:0] bcnt);
    logic [31:0] m;
    case (bcnt)
      2'd0:    m = 32'h0000_0000;
      2'd1:    m = 32'hFF00_0000;
      2'd2:    m = 32'hFFFF_0000;
      default: m = 32'hFFFF_FF00;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/vga_colpack_lane.sv
// -----------------------------------------------------------------------------
// vga_colpack_lane
// Combinational pixel converter and byte merger.
// Converts one R/G/B pixel into 1..3 bytes according to ColorDepth and merges
// them into the accumulator starting at lane bcnt.
// Ports:
//   color_depth  in   2   pixel format select
//   r, g, b      in   8   pixel channels
//   acc          in  32   current accumulator (unfilled lanes are zero)
//   bcnt         in   2   bytes already in acc
//   acc_next     out 32   accumulator after this pixel (overflow bytes at lane 0)
//   word         out 32   completed word, meaningful when wrap=1
//   bcnt_next    out  2   (bcnt + n) mod 4
//   wrap         out  1   this pixel completes a word
// -----------------------------------------------------------------------------
module vga_colpack_lane
  import vga_pkg::*;
(
  input  logic [1:0]  color_depth,
  input  logic [7:0]  r,
  input  logic [7:0]  g,
  input  logic [7:0]  b,
  input  logic [31:0] acc,
  input  logic [1:0]  bcnt,
  output logic [31:0] acc_next,
  output logic [31:0] word,
  output logic [1:0]  bcnt_next,
  output logic        wrap
);

  logic [9:0]  grey_sum;
  logic [23:0] pix;     // pixel bytes, first byte in [23:16], unused bytes zero
  logic [1:0]  n;       // bytes produced by this pixel
  logic [2:0]  fill;
  logic [63:0] merged;  // two-word window: current word above, overflow below

  // Weighted sum R + 2G + B needs 10 bits; >>2 keeps the top 8.
  assign grey_sum = {2'b00, r} + {1'b0, g, 1'b0} + {2'b00, b};

  // NOTE: every output of an always_comb gets a default first, so no path
  // through the case can leave it unassigned and infer a latch.
  always_comb begin
    pix = '0;
    n   = 2'd1;
    case (decode_depth(color_depth))
      FMT_GREY: begin
        pix = {grey_sum[9:2], 16'h0000};
        n   = 2'd1;
      end
      FMT_RGB565: begin
        pix = {r[7:3], g[7:5], g[4:2], b[7:3], 8'h00};
        n   = 2'd2;
      end
      default: begin
        pix = {r, g, b};
        n   = 2'd3;
      end
    endcase
  end

  // Shifting the pixel down by bcnt lanes lines it up behind the bytes already
  // held; anything past lane 3 spills into the lower word as the next acc.
  assign merged    = {acc, 32'h0000_0000} | ({pix, 40'h0} >> {bcnt, 3'b000});
  assign fill      = {1'b0, bcnt} + {1'b0, n};
  assign wrap      = fill[2];
  assign bcnt_next = fill[1:0];
  assign word      = merged[63:32];
  assign acc_next  = wrap ? merged[31:0] : merged[63:32];

endmodule

// File: rtl/vga_colpack.sv
// -----------------------------------------------------------------------------
// vga_colpack
// Packs RGB pixels read from a source FIFO into 32-bit words for the pixel
// buffer write FIFO. Formats: 8bpp grey, 16bpp RGB565, 24bpp packed RGB.
// The first pixel of a word occupies the MSBs.
// Ports:
//   clk                in   1   master clock
//   rst                in   1   asynchronous active-high reset
//   ColorDepth         in   2   00=8bpp, 01=16bpp, 1x=24bpp; static while busy
//   RGB_fifo_empty     in   1   source FIFO empty
//   RGB_fifo_rreq      out  1   source read request, data valid next cycle
//   R, G, B            in   8   pixel data from the source FIFO
//   pixel_buffer_full  in   1   destination FIFO full
//   pixel_buffer_wreq  out  1   destination write strobe, one cycle per word
//   pixel_buffer_do    out 32   packed word, valid with pixel_buffer_wreq
//   flush              in   1   pulse: emit a partially filled word
//   busy               out  1   packer holds data or has a request in flight
// -----------------------------------------------------------------------------
module vga_colpack
  import vga_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  ColorDepth,
  input  logic        RGB_fifo_empty,
  output logic        RGB_fifo_rreq,
  input  logic [7:0]  R,
  input  logic [7:0]  G,
  input  logic [7:0]  B,
  input  logic        pixel_buffer_full,
  output logic        pixel_buffer_wreq,
  output logic [31:0] pixel_buffer_do,
  input  logic        flush,
  output logic        busy
);

  logic [31:0] acc;
  logic [1:0]  bcnt;
  logic [31:0] hold;
  logic        wpend;
  logic        flush_pend;
  logic        vld;

  logic [31:0] acc_next;
  logic [31:0] word;
  logic [1:0]  bcnt_next;
  logic        wrap;
  logic        wdone;

  vga_colpack_lane u_lane (
    .color_depth (ColorDepth),
    .r           (R),
    .g           (G),
    .b           (B),
    .acc         (acc),
    .bcnt        (bcnt),
    .acc_next    (acc_next),
    .word        (word),
    .bcnt_next   (bcnt_next),
    .wrap        (wrap)
  );

  assign wdone = vld & wrap;

  // A read is only issued when hold is guaranteed free by the time the pixel
  // arrives: no word waiting, none completing this cycle, no flush queued.
  // The request is also masked during reset so every output reads zero then.
  assign RGB_fifo_rreq = !rst && !RGB_fifo_empty && !wpend && !wdone && !flush_pend;

  assign busy = vld | wpend | flush_pend | (bcnt != 2'd0);

  // NOTE: sequential state uses non-blocking assignments only, so every read
  // in this block sees the value from before the clock edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: acc and hold are plain registers rather than a memory array, so
      // they reset together with the control state; nothing stale survives.
      acc               <= '0;
      bcnt              <= 2'd0;
      hold              <= '0;
      wpend             <= 1'b0;
      flush_pend        <= 1'b0;
      vld               <= 1'b0;
      pixel_buffer_wreq <= 1'b0;
      pixel_buffer_do   <= '0;
    end else begin
      vld               <= RGB_fifo_rreq;
      pixel_buffer_wreq <= 1'b0;

      if (wpend && !pixel_buffer_full) begin
        pixel_buffer_do   <= hold;
        pixel_buffer_wreq <= 1'b1;
        wpend             <= 1'b0;
      end

      // The read gating means hold is empty whenever vld is set, so a
      // completed word never collides with the drain above.
      if (vld) begin
        acc  <= acc_next;
        bcnt <= bcnt_next;
        if (wdone) begin
          hold  <= word;
          wpend <= 1'b1;
        end
      end else if (flush_pend && !wpend) begin
        if (bcnt != 2'd0) begin
          hold  <= acc & lane_mask(bcnt);
          wpend <= 1'b1;
          bcnt  <= 2'd0;
          acc   <= '0;
        end
        flush_pend <= 1'b0;
      end

      // A new pulse always leaves a flush queued, even on the cycle an
      // earlier one executes; the repeat then finds bcnt=0 and is a no-op.
      if (flush) flush_pend <= 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_colpack.sv
module tb_vga_colpack;
  import vga_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  ColorDepth = CD_8BPP;
  logic        RGB_fifo_empty = 1'b1;
  logic        RGB_fifo_rreq;
  logic [7:0]  R = 8'h00, G = 8'h00, B = 8'h00;
  logic        pixel_buffer_full = 1'b0;
  logic        pixel_buffer_wreq;
  logic [31:0] pixel_buffer_do;
  logic        flush = 1'b0;
  logic        busy;

  always #5 clk = ~clk;

  vga_colpack dut (
    .clk               (clk),
    .rst               (rst),
    .ColorDepth        (ColorDepth),
    .RGB_fifo_empty    (RGB_fifo_empty),
    .RGB_fifo_rreq     (RGB_fifo_rreq),
    .R                 (R),
    .G                 (G),
    .B                 (B),
    .pixel_buffer_full (pixel_buffer_full),
    .pixel_buffer_wreq (pixel_buffer_wreq),
    .pixel_buffer_do   (pixel_buffer_do),
    .flush             (flush),
    .busy              (busy)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- source FIFO model (show-next-cycle) ----------------
  typedef struct packed { logic [7:0] r, g, b; } pix_t;
  pix_t src_q[$];
  pix_t cur;
  logic rd_s = 1'b0;

  always @(posedge clk) begin
    #1;
    if (rd_s && src_q.size() > 0) begin
      cur = src_q.pop_front();
      R = cur.r; G = cur.g; B = cur.b;
    end
    RGB_fifo_empty = (src_q.size() == 0);
  end

  // ---------------- monitor: reads, writes, depth legality ----------------
  logic [31:0] rx_q[$];
  int   rd_cnt = 0;
  int   wr_cnt = 0;
  logic [1:0] last_cd = CD_8BPP;
  logic last_busy = 1'b0;
  logic rand_bp = 1'b0;

  always @(negedge clk) begin
    rd_s = RGB_fifo_rreq;
    if (RGB_fifo_rreq) rd_cnt++;
    if (pixel_buffer_wreq) begin
      rx_q.push_back(pixel_buffer_do);
      wr_cnt++;
    end
    if (ColorDepth !== last_cd) check("depth_change_while_busy", 32'(last_busy), 32'd0);
    last_cd   = ColorDepth;
    last_busy = busy;
    if (rand_bp) pixel_buffer_full = ($urandom_range(0, 2) == 0);
  end

  // ---------------- behavioural reference: byte stream ----------------
  logic [7:0] exp_bytes[$];

  task automatic model_push(input logic [1:0] cd, input logic [7:0] r, g, b);
    int ri, gi, bi;
    ri = int'(r); gi = int'(g); bi = int'(b);
    if (cd == CD_8BPP) begin
      exp_bytes.push_back(8'((ri + 2 * gi + bi) / 4));
    end else if (cd == CD_16BPP) begin
      exp_bytes.push_back(8'((ri / 8) * 8 + gi / 32));
      exp_bytes.push_back(8'(((gi / 4) % 8) * 32 + bi / 8));
    end else begin
      exp_bytes.push_back(r);
      exp_bytes.push_back(g);
      exp_bytes.push_back(b);
    end
  endtask

  // Group the expected byte stream into MSB-first words, zero-filling the tail.
  task automatic compare_stream(input string name);
    logic [31:0] w;
    int nw;
    nw = (exp_bytes.size() + 3) / 4;
    check({name, "_nwords"}, 32'(rx_q.size()), 32'(nw));
    for (int i = 0; i < nw; i++) begin
      w = 32'h0;
      for (int j = 0; j < 4; j++)
        if (exp_bytes.size() > 0) w = w | (32'(exp_bytes.pop_front()) << (24 - 8 * j));
      if (i < rx_q.size()) check($sformatf("%s_w%0d", name, i), rx_q[i], w);
    end
    exp_bytes.delete();
    rx_q.delete();
  endtask

  // ---------------- helpers ----------------
  task automatic push(input logic [7:0] r, g, b);
    src_q.push_back({r, g, b});
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic wait_src_empty(input string name);
    int t = 0;
    while (src_q.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    check({name, "_src_drain_timeout"}, 32'(t >= 3000), 32'd0);
    cycles(2);  // last popped pixel reaches the accumulator
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (busy && t < 3000) begin @(negedge clk); t++; end
    check({name, "_idle_timeout"}, 32'(t >= 3000), 32'd0);
    cycles(2);  // let the monitor capture the final write
  endtask

  task automatic pulse_flush;
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
  endtask

  task automatic check_rx(input string name, input int n, input logic [31:0] w0, w1, w2);
    check({name, "_nwords"}, 32'(rx_q.size()), 32'(n));
    if (n > 0 && rx_q.size() > 0) check({name, "_w0"}, rx_q[0], w0);
    if (n > 1 && rx_q.size() > 1) check({name, "_w1"}, rx_q[1], w1);
    if (n > 2 && rx_q.size() > 2) check({name, "_w2"}, rx_q[2], w2);
    rx_q.delete();
  endtask

  // ---------------- single-pixel conversion table ----------------
  typedef struct {
    logic [1:0]  cd;
    logic [7:0]  r, g, b;
    logic [31:0] exp;   // word emitted by flushing that lone pixel
  } vec_t;
  vec_t vecs[10];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd0, wr0, k, t, npix;
    logic [1:0] cd;
    logic [7:0] r, g, b;

    vecs[0] = '{CD_8BPP,  8'h10, 8'h20, 8'h30, 32'h2000_0000};
    vecs[1] = '{CD_8BPP,  8'hFF, 8'hFF, 8'hFF, 32'hFF00_0000};
    vecs[2] = '{CD_8BPP,  8'h01, 8'hFF, 8'h02, 32'h8000_0000};
    vecs[3] = '{CD_8BPP,  8'h03, 8'h00, 8'h00, 32'h0000_0000};
    vecs[4] = '{CD_8BPP,  8'hFF, 8'hFF, 8'hFE, 32'hFE00_0000};
    vecs[5] = '{CD_16BPP, 8'hFF, 8'hFF, 8'hFF, 32'hFFFF_0000};
    vecs[6] = '{CD_16BPP, 8'h08, 8'h04, 8'h08, 32'h0821_0000};
    vecs[7] = '{CD_16BPP, 8'h12, 8'h34, 8'h56, 32'h11AA_0000};
    vecs[8] = '{CD_24BPP, 8'h01, 8'h02, 8'h03, 32'h0102_0300};
    vecs[9] = '{2'b11,    8'hAA, 8'hBB, 8'hCC, 32'hAABB_CC00};

    // ---- reset state ----
    cycles(3);
    check("rst_rreq", 32'(RGB_fifo_rreq), 32'd0);
    check("rst_wreq", 32'(pixel_buffer_wreq), 32'd0);
    check("rst_do", pixel_buffer_do, 32'h0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    cycles(2);

    // ---- 8bpp grey, no backpressure, with write latency ----
    ColorDepth = CD_8BPP;
    push(8'h10, 8'h20, 8'h30); push(8'hFF, 8'hFF, 8'hFF);
    push(8'h00, 8'h00, 8'h00); push(8'h40, 8'h40, 8'h40);
    t = 0;
    while (!RGB_fifo_rreq && t < 50) begin @(negedge clk); t++; end
    check("g8_first_read_timeout", 32'(t >= 50), 32'd0);
    k = 0;
    while (!pixel_buffer_wreq && k < 50) begin @(negedge clk); k++; end
    // First pixel is valid the cycle after the read; the word is complete in
    // hold 4 cycles after that and the registered strobe follows one cycle later.
    check("g8_latency_from_first_pixel", 32'(k - 1), 32'd5);
    wait_idle("g8");
    check_rx("g8", 1, 32'h20FF_0040, 32'h0, 32'h0);

    // ---- 16bpp ----
    ColorDepth = CD_16BPP;
    push(8'hFF, 8'hFF, 8'hFF); push(8'h08, 8'h04, 8'h08);
    wait_src_empty("c16");
    wait_idle("c16");
    check_rx("c16", 1, 32'hFFFF_0821, 32'h0, 32'h0);

    // ---- 24bpp ----
    ColorDepth = CD_24BPP;
    push(8'h01, 8'h02, 8'h03); push(8'h04, 8'h05, 8'h06);
    push(8'h07, 8'h08, 8'h09); push(8'h0A, 8'h0B, 8'h0C);
    wait_src_empty("c24");
    wait_idle("c24");
    check_rx("c24", 3, 32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C);
    check("c24_busy_after", 32'(busy), 32'd0);

    // ---- backpressure ----
    ColorDepth = CD_8BPP;
    pixel_buffer_full = 1'b1;
    rd0 = rd_cnt; wr0 = wr_cnt;
    for (int i = 1; i <= 8; i++) push(8'(i), 8'(i), 8'(i));
    cycles(20);
    check("bp_reads_while_full", 32'(rd_cnt - rd0), 32'd4);
    check("bp_writes_while_full", 32'(wr_cnt - wr0), 32'd0);
    check("bp_rreq_low_while_full", 32'(RGB_fifo_rreq), 32'd0);
    check("bp_busy_while_full", 32'(busy), 32'd1);
    pixel_buffer_full = 1'b0;
    wait_src_empty("bp");
    wait_idle("bp");
    check("bp_total_reads", 32'(rd_cnt - rd0), 32'd8);
    check_rx("bp", 2, 32'h0102_0304, 32'h0506_0708, 32'h0);

    // ---- flush of a partial word, then a redundant flush ----
    push(8'hAB, 8'hAB, 8'hAB);
    wait_src_empty("fl");
    check("fl_busy_partial", 32'(busy), 32'd1);
    pulse_flush();
    wait_idle("fl");
    check_rx("fl", 1, 32'hAB00_0000, 32'h0, 32'h0);
    check("fl_busy_after", 32'(busy), 32'd0);
    wr0 = wr_cnt;
    pulse_flush();
    cycles(5);
    check("fl2_no_write", 32'(wr_cnt - wr0), 32'd0);
    check("fl2_busy", 32'(busy), 32'd0);

    // ---- single-pixel conversion table ----
    for (int i = 0; i < 10; i++) begin
      ColorDepth = vecs[i].cd;
      push(vecs[i].r, vecs[i].g, vecs[i].b);
      wait_src_empty($sformatf("vec%0d", i));
      pulse_flush();
      wait_idle($sformatf("vec%0d", i));
      check($sformatf("vec%0d_nwords", i), 32'(rx_q.size()), 32'd1);
      if (rx_q.size() > 0) check($sformatf("vec%0d_word", i), rx_q[0], vecs[i].exp);
      rx_q.delete();
    end

    // ---- reset mid-operation (24bpp) ----
    ColorDepth = CD_24BPP;
    rd0 = rd_cnt;
    push(8'hE1, 8'hE2, 8'hE3); push(8'hE4, 8'hE5, 8'hE6); push(8'hE7, 8'hE8, 8'hE9);
    t = 0;
    while (rd_cnt - rd0 < 2 && t < 50) begin @(negedge clk); t++; end
    check("rm_two_reads_timeout", 32'(t >= 50), 32'd0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("rm_rreq_async", 32'(RGB_fifo_rreq), 32'd0);
    check("rm_wreq_async", 32'(pixel_buffer_wreq), 32'd0);
    check("rm_do_async", pixel_buffer_do, 32'h0);
    check("rm_busy_async", 32'(busy), 32'd0);
    src_q.delete();
    cycles(3);
    rx_q.delete();
    rst = 1'b0;
    cycles(2);
    push(8'h01, 8'h02, 8'h03); push(8'h04, 8'h05, 8'h06);
    push(8'h07, 8'h08, 8'h09); push(8'h0A, 8'h0B, 8'h0C);
    wait_src_empty("rm");
    wait_idle("rm");
    check_rx("rm", 3, 32'h0102_0304, 32'h0506_0708, 32'h090A_0B0C);

    // ---- randomized frames against the reference model ----
    rand_bp = 1'b1;
    for (int it = 0; it < 30; it++) begin
      cd   = 2'($urandom_range(0, 3));
      npix = $urandom_range(1, 12);
      ColorDepth = cd;
      for (int p = 0; p < npix; p++) begin
        r = 8'($urandom); g = 8'($urandom); b = 8'($urandom);
        push(r, g, b);
        model_push(cd, r, g, b);
      end
      wait_src_empty($sformatf("rnd%0d", it));
      pulse_flush();
      wait_idle($sformatf("rnd%0d", it));
      compare_stream($sformatf("rnd%0d", it));
    end
    rand_bp = 1'b0;
    pixel_buffer_full = 1'b0;
    cycles(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
